// File: rtl/run_ctrl_pkg.sv
// Shared types for the run sequencer: FSM state encoding and run completion status.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    TIMEOUT = 2'd1,
    ABORTED = 2'd2
  } status_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear, count enable, saturation at all-ones and
// a terminal-value compare.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             at_term
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign at_term = (count == term);

endmodule

// File: rtl/run_controller.sv
// Run sequencer: holds cores in reset, enables them for a bounded run and
// stops on all-halt, budget expiry or abort, reporting count and status.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int NUM_CORES  = 1,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     max_cycles,
  input  logic [NUM_CORES-1:0] core_halt,
  output logic                 core_rst,
  output logic [NUM_CORES-1:0] core_en,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic                 aborted,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [NUM_CORES-1:0] halted
);

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

  state_t               state, state_nxt;
  status_t              exit_status;
  logic [CNT_W-1:0]     budget;
  logic                 accept;
  logic                 in_run;
  logic                 in_reset;
  logic                 cyc_term;
  logic                 rst_last;
  logic [RST_W-1:0]     rst_count_unused;
  logic [NUM_CORES-1:0] halt_set;
  logic [NUM_CORES-1:0] halted_nxt;
  logic [NUM_CORES-1:0] core_en_nxt;
  logic                 core_rst_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;
  logic                 timeout_nxt;
  logic                 aborted_nxt;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign in_run   = (state == RUN);
  assign in_reset = (state == RESET);

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .en      (in_run),
    .term    (budget - CNT_W'(1)),
    .count   (cycle_count),
    .at_term (cyc_term)
  );

  // Counts up from 0 to RST_CYCLES-1, equivalent to a down-count from RST_CYCLES-1.
  sat_counter #(.WIDTH(RST_W)) u_rst_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .en      (in_reset),
    .term    (RST_LAST),
    .count   (rst_count_unused),
    .at_term (rst_last)
  );

  always_comb begin
    state_nxt   = state;
    exit_status = OK;
    halt_set    = '0;
    halted_nxt  = halted;
    timeout_nxt = timeout;
    aborted_nxt = aborted;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt   = RESET;
          halted_nxt  = '0;
          timeout_nxt = 1'b0;
          aborted_nxt = 1'b0;
        end
      end
      RESET: begin
        if (abort) begin
          state_nxt   = DONE;
          exit_status = ABORTED;
        end else if (rst_last) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        halt_set   = core_en & core_halt;
        halted_nxt = halted | halt_set;
        // Abort beats halt, and a final halt beats budget expiry in the same cycle.
        if (abort) begin
          state_nxt   = DONE;
          exit_status = ABORTED;
        end else if (&halted_nxt) begin
          state_nxt   = DONE;
          exit_status = OK;
        end else if ((budget != '0) && cyc_term) begin
          state_nxt   = DONE;
          exit_status = TIMEOUT;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if ((state_nxt == DONE) && (state != DONE)) begin
      timeout_nxt = (exit_status == TIMEOUT);
      aborted_nxt = (exit_status == ABORTED);
    end

    core_rst_nxt = (state_nxt == IDLE) || (state_nxt == RESET);
    busy_nxt     = (state_nxt == RESET) || (state_nxt == RUN);
    done_nxt     = (state_nxt == DONE);
    core_en_nxt  = (state_nxt == RUN) ? ~halted_nxt : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      core_rst <= 1'b1;
      core_en  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      aborted  <= 1'b0;
      halted   <= '0;
      budget   <= '0;
    end else begin
      state    <= state_nxt;
      core_rst <= core_rst_nxt;
      core_en  <= core_en_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      timeout  <= timeout_nxt;
      aborted  <= aborted_nxt;
      halted   <= halted_nxt;
      if (accept) begin
        budget <= max_cycles;
      end
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: a single-core instance with a 3-cycle reset and a
// two-core instance with a 1-cycle reset, driven by vectors and run sequences.
module tb_run_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        a_start = 1'b0, a_abort = 1'b0;
  logic [15:0] a_max = '0;
  logic [0:0]  a_halt = '0;
  logic        a_core_rst, a_busy, a_done, a_timeout, a_aborted;
  logic [0:0]  a_core_en, a_halted;
  logic [15:0] a_cycle_count;

  logic        b_start = 1'b0, b_abort = 1'b0;
  logic [15:0] b_max = '0;
  logic [1:0]  b_halt = '0;
  logic        b_core_rst, b_busy, b_done, b_timeout, b_aborted;
  logic [1:0]  b_core_en, b_halted;
  logic [15:0] b_cycle_count;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  run_controller #(.NUM_CORES(1), .CNT_W(16), .RST_CYCLES(3)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .abort(a_abort),
    .max_cycles(a_max), .core_halt(a_halt), .core_rst(a_core_rst),
    .core_en(a_core_en), .busy(a_busy), .done(a_done), .timeout(a_timeout),
    .aborted(a_aborted), .cycle_count(a_cycle_count), .halted(a_halted)
  );

  run_controller #(.NUM_CORES(2), .CNT_W(16), .RST_CYCLES(1)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
    .max_cycles(b_max), .core_halt(b_halt), .core_rst(b_core_rst),
    .core_en(b_core_en), .busy(b_busy), .done(b_done), .timeout(b_timeout),
    .aborted(b_aborted), .cycle_count(b_cycle_count), .halted(b_halted)
  );

  // Expected packing: {core_rst, core_en[1:0], busy, done, timeout, aborted, halted[1:0], cycle_count}
  typedef struct packed {
    logic        start;
    logic [15:0] mc;
    logic [1:0]  halt;
    logic        abort;
    logic [24:0] exp;
  } vec_t;

  typedef struct {
    int rst_cyc;
    int en_cyc;
    bit first_clear;
    bit restarted;
    bit finished;
  } run_res_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic st, input logic [15:0] mc, input logic [1:0] h,
                              input logic ab_in, input logic rst, input logic [1:0] en,
                              input logic bsy, input logic dn, input logic to, input logic ab,
                              input logic [1:0] hl, input logic [15:0] cnt);
    vec_t v;
    v.start = st;
    v.mc    = mc;
    v.halt  = h;
    v.abort = ab_in;
    v.exp   = {rst, en, bsy, dn, to, ab, hl, cnt};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Starts a run on u_a and follows it until done, steering halt/abort/start by RUN cycle index.
  task automatic run_a(input logic [15:0] mc, input int halt_at, input int abort_at,
                       input int start_at, input bit abort_rst, output run_res_t r);
    bit seen_run;
    bit in_run;
    r.rst_cyc = 0;
    r.en_cyc = 0;
    r.restarted = 0;
    seen_run = 0;
    a_start = 1'b1;
    a_max = mc;
    @(posedge clk); #1;
    a_start = 1'b0;
    r.first_clear = (a_done == 1'b0) && (a_timeout == 1'b0) && (a_aborted == 1'b0) &&
                    (a_cycle_count == 16'd0) && (a_halted == 1'b0);
    for (int i = 0; i < 200 && !a_done; i++) begin
      in_run = a_busy && !a_core_rst;
      if (a_core_rst) begin
        r.rst_cyc++;
        if (seen_run) r.restarted = 1;
      end
      if (a_core_en[0]) r.en_cyc++;
      if (in_run) seen_run = 1;
      a_halt[0] = in_run && (int'(a_cycle_count) == halt_at);
      a_abort   = (in_run && (int'(a_cycle_count) == abort_at)) || (abort_rst && a_busy && a_core_rst);
      a_start   = in_run && (int'(a_cycle_count) == start_at);
      @(posedge clk); #1;
    end
    a_halt = '0;
    a_abort = 1'b0;
    a_start = 1'b0;
    r.finished = a_done;
  endtask

  initial begin
    run_res_t r;

    // in: start, mc, halt, abort | exp: rst, en, busy, done, to, ab, halted, cnt
    vecs[0]  = mk(1'b0, 16'd0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0);
    vecs[1]  = mk(1'b1, 16'd0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0);
    vecs[2]  = mk(1'b0, 16'd0, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0);
    vecs[3]  = mk(1'b0, 16'd0, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'd1);
    vecs[4]  = mk(1'b0, 16'd0, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'd2);
    vecs[5]  = mk(1'b1, 16'd9, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'd3);
    vecs[6]  = mk(1'b0, 16'd0, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'd4);
    vecs[7]  = mk(1'b0, 16'd0, 2'b01, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'd5);
    vecs[8]  = mk(1'b0, 16'd0, 2'b01, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'd6);
    vecs[9]  = mk(1'b0, 16'd0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'd7);
    vecs[10] = mk(1'b0, 16'd0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'd8);
    vecs[11] = mk(1'b0, 16'd0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'd9);
    vecs[12] = mk(1'b0, 16'd0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 16'd10);
    vecs[13] = mk(1'b0, 16'd0, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 16'd10);

    #3 reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("a_reset_state", 32'({a_core_rst, a_core_en, a_busy, a_done, a_timeout, a_aborted, a_halted, a_cycle_count}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}));
    chk("b_reset_state", 32'({b_core_rst, b_core_en, b_busy, b_done, b_timeout, b_aborted, b_halted, b_cycle_count}),
        32'({1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0}));
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Two cores, unlimited budget: core 0 halts in RUN cycle 4, core 1 in cycle 9.
    for (int i = 0; i < 14; i++) begin
      b_start = vecs[i].start;
      b_max   = vecs[i].mc;
      b_halt  = vecs[i].halt;
      b_abort = vecs[i].abort;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i),
          32'({b_core_rst, b_core_en, b_busy, b_done, b_timeout, b_aborted, b_halted, b_cycle_count}),
          32'(vecs[i].exp));
    end
    b_start = 1'b0;
    b_halt = '0;
    b_abort = 1'b0;

    // Budget 15, no halt.
    run_a(16'd15, -1, -1, -1, 1'b0, r);
    chk("to15_finished", 32'(r.finished), 32'd1);
    chk("to15_rst_cycles", 32'(r.rst_cyc), 32'd3);
    chk("to15_en_cycles", 32'(r.en_cyc), 32'd15);
    chk("to15_flags", 32'({a_done, a_busy, a_core_rst, a_core_en, a_timeout, a_aborted}), 32'b100010);
    chk("to15_count", 32'(a_cycle_count), 32'd15);

    // Restart from DONE with budget 5.
    run_a(16'd5, -1, -1, -1, 1'b0, r);
    chk("rs5_first_clear", 32'(r.first_clear), 32'd1);
    chk("rs5_rst_cycles", 32'(r.rst_cyc), 32'd3);
    chk("rs5_en_cycles", 32'(r.en_cyc), 32'd5);
    chk("rs5_timeout", 32'({a_done, a_timeout, a_aborted}), 32'b110);
    chk("rs5_count", 32'(a_cycle_count), 32'd5);

    // Abort while in DONE is ignored.
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0;
    chk("done_abort_ignored", 32'({a_done, a_timeout, a_aborted, a_busy}), 32'b1100);

    // Budget 8, halt in the last cycle: halt wins.
    run_a(16'd8, 7, -1, -1, 1'b0, r);
    chk("hl8_flags", 32'({a_done, a_timeout, a_aborted, a_halted}), 32'b1001);
    chk("hl8_count", 32'(a_cycle_count), 32'd8);
    chk("hl8_en_cycles", 32'(r.en_cyc), 32'd8);

    // Abort with halt in RUN cycle 3, start pulse in cycle 1 ignored.
    run_a(16'd0, 3, 3, 1, 1'b0, r);
    chk("ab3_flags", 32'({a_done, a_timeout, a_aborted}), 32'b101);
    chk("ab3_count", 32'(a_cycle_count), 32'd4);
    chk("ab3_no_restart", 32'(r.restarted), 32'd0);
    chk("ab3_rst_cycles", 32'(r.rst_cyc), 32'd3);

    // Abort during RESET.
    run_a(16'd10, -1, -1, -1, 1'b1, r);
    chk("abr_flags", 32'({a_done, a_timeout, a_aborted, a_core_rst}), 32'b1010);
    chk("abr_count", 32'(a_cycle_count), 32'd0);
    chk("abr_en_cycles", 32'(r.en_cyc), 32'd0);

    // Reset asserted mid-RUN at cycle 7 of a 20-cycle budget, checked before any edge.
    a_start = 1'b1;
    a_max = 16'd20;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int i = 0; i < 100 && !(a_busy && !a_core_rst && a_cycle_count == 16'd7); i++) begin
      @(posedge clk); #1;
    end
    chk("mid_reached_c7", 32'(a_cycle_count), 32'd7);
    reset = 1'b0;
    #1;
    chk("mid_reset_state", 32'({a_core_rst, a_core_en, a_busy, a_done, a_timeout, a_aborted, a_halted, a_cycle_count}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}));
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
